// File: rtl/wt_cache_pkg.sv
// Shared write-through cache types, geometry and address slicing helpers.
package wt_cache_pkg;

  localparam int unsigned PLEN                 = 32;
  localparam int unsigned DCACHE_SET_ASSOC     = 4;
  localparam int unsigned DCACHE_LINE_WIDTH    = 256;
  localparam int unsigned DCACHE_INDEX_WIDTH   = 12;
  localparam int unsigned DCACHE_OFFSET_WIDTH  = $clog2(DCACHE_LINE_WIDTH / 8);
  localparam int unsigned DCACHE_CL_IDX_WIDTH  = DCACHE_INDEX_WIDTH - DCACHE_OFFSET_WIDTH;
  localparam int unsigned DCACHE_TAG_WIDTH     = PLEN - DCACHE_INDEX_WIDTH;
  localparam int unsigned DCACHE_WAY_IDX_WIDTH = $clog2(DCACHE_SET_ASSOC);
  localparam int unsigned CACHE_ID_WIDTH       = 4;
  localparam int unsigned MSHR_PORT_WIDTH      = 4;

  typedef enum logic [1:0] {
    MSHR_IDLE  = 2'd0,
    MSHR_ISSUE = 2'd1,
    MSHR_WAIT  = 2'd2
  } mshr_state_e;

  typedef struct packed {
    logic [PLEN-1:0]             paddr;
    logic [2:0]                  size;
    logic                        nc;
    logic [DCACHE_SET_ASSOC-1:0] vld_bits;
    logic [MSHR_PORT_WIDTH-1:0]  port;
  } mshr_t;

  function automatic logic [DCACHE_CL_IDX_WIDTH-1:0] cl_idx(input logic [PLEN-1:0] paddr);
    return DCACHE_CL_IDX_WIDTH'(paddr >> DCACHE_OFFSET_WIDTH);
  endfunction

  function automatic logic [DCACHE_TAG_WIDTH-1:0] cl_tag(input logic [PLEN-1:0] paddr);
    return DCACHE_TAG_WIDTH'(paddr >> DCACHE_INDEX_WIDTH);
  endfunction

  // Line-aligned address: offset bits cleared.
  function automatic logic [PLEN-1:0] cl_align(input logic [PLEN-1:0] paddr);
    return (paddr >> DCACHE_OFFSET_WIDTH) << DCACHE_OFFSET_WIDTH;
  endfunction

  // True when two addresses fall in the same cacheline (idx + tag equal).
  function automatic logic same_line(input logic [PLEN-1:0] a, input logic [PLEN-1:0] b);
    return (a >> DCACHE_OFFSET_WIDTH) == (b >> DCACHE_OFFSET_WIDTH);
  endfunction

endpackage

// File: rtl/wt_dcache_victim_sel.sv
// Victim way selection: first invalid way, else a round-robin pointer that
// advances only when a full set actually gets a line written into it.
module wt_dcache_victim_sel
  import wt_cache_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [DCACHE_SET_ASSOC-1:0] vld_bits_i,
  input  logic                        upd_i,
  output logic [DCACHE_SET_ASSOC-1:0] way_oh_o
);

  logic [DCACHE_WAY_IDX_WIDTH-1:0] rr_q, rr_d;
  logic                            all_vld;
  logic                            found;

  always_comb begin
    way_oh_o = '0;
    found    = 1'b0;
    all_vld  = &vld_bits_i;
    rr_d     = rr_q;
    for (int unsigned i = 0; i < DCACHE_SET_ASSOC; i++) begin
      if (!vld_bits_i[i] && !found) begin
        way_oh_o[i] = 1'b1;
        found       = 1'b1;
      end
    end
    if (all_vld) begin
      way_oh_o[rr_q] = 1'b1;
      if (upd_i) begin
        rr_d = (rr_q == DCACHE_WAY_IDX_WIDTH'(DCACHE_SET_ASSOC - 1)) ? '0
                                                                     : rr_q + DCACHE_WAY_IDX_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/wt_dcache_miss_rsp.sv
// Single-MSHR responder for dcache read-port misses: arbitrate, issue, refill.
// Optional perf counters enabled with `define WT_DCACHE_MISS_PERF_EN.
module wt_dcache_miss_rsp
  import wt_cache_pkg::*;
#(
  parameter int unsigned               NumPorts = 3,
  parameter logic [CACHE_ID_WIDTH-1:0] RdTxId   = CACHE_ID_WIDTH'(1)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NumPorts-1:0]                    miss_req_i,
  output logic [NumPorts-1:0]                    miss_ack_o,
  output logic [NumPorts-1:0]                    miss_replay_o,
  input  logic [NumPorts-1:0]                    miss_nc_i,
  input  logic [NumPorts*PLEN-1:0]               miss_paddr_i,
  input  logic [NumPorts*3-1:0]                  miss_size_i,
  input  logic [NumPorts*DCACHE_SET_ASSOC-1:0]   miss_vld_bits_i,
  output logic [NumPorts-1:0]                    miss_rtrn_vld_o,
  output logic [DCACHE_LINE_WIDTH-1:0]           rtrn_data_o,
  output logic                                   mem_req_o,
  input  logic                                   mem_ack_i,
  output logic [PLEN-1:0]                        mem_paddr_o,
  output logic [2:0]                             mem_size_o,
  output logic                                   mem_nc_o,
  output logic [CACHE_ID_WIDTH-1:0]              mem_id_o,
  input  logic                                   mem_rtrn_vld_i,
  input  logic [DCACHE_LINE_WIDTH-1:0]           mem_rtrn_data_i,
  output logic                                   wr_cl_vld_o,
  output logic [DCACHE_SET_ASSOC-1:0]            wr_cl_we_o,
  output logic [DCACHE_CL_IDX_WIDTH-1:0]         wr_cl_idx_o,
  output logic [DCACHE_TAG_WIDTH-1:0]            wr_cl_tag_o,
  output logic [DCACHE_LINE_WIDTH-1:0]           wr_cl_data_o,
  output logic [31:0]                            miss_cnt_o,
  output logic [31:0]                            replay_cnt_o
);

  mshr_state_e                 state_q, state_d;
  mshr_t                       mshr_q, mshr_d;
  logic                        sel_found;
  logic                        cl_write;
  logic [DCACHE_SET_ASSOC-1:0] victim_way;

  always_comb begin
    state_d         = state_q;
    mshr_d          = mshr_q;
    sel_found       = 1'b0;
    cl_write        = 1'b0;
    miss_ack_o      = '0;
    miss_replay_o   = '0;
    miss_rtrn_vld_o = '0;
    rtrn_data_o     = '0;
    mem_req_o       = 1'b0;
    mem_paddr_o     = '0;
    mem_size_o      = '0;
    mem_nc_o        = 1'b0;
    mem_id_o        = '0;
    wr_cl_vld_o     = 1'b0;
    wr_cl_we_o      = '0;
    wr_cl_idx_o     = '0;
    wr_cl_tag_o     = '0;
    wr_cl_data_o    = '0;

    unique case (state_q)
      // Fixed priority: lowest port index wins, acked in the same cycle.
      MSHR_IDLE: begin
        for (int unsigned i = 0; i < NumPorts; i++) begin
          if (miss_req_i[i] && !sel_found) begin
            sel_found       = 1'b1;
            miss_ack_o[i]   = 1'b1;
            mshr_d.paddr    = miss_paddr_i[i*PLEN +: PLEN];
            mshr_d.size     = miss_size_i[i*3 +: 3];
            mshr_d.nc       = miss_nc_i[i];
            mshr_d.vld_bits = miss_vld_bits_i[i*DCACHE_SET_ASSOC +: DCACHE_SET_ASSOC];
            mshr_d.port     = MSHR_PORT_WIDTH'(i);
          end
        end
        if (sel_found) begin
          state_d = MSHR_ISSUE;
        end
      end

      MSHR_ISSUE: begin
        mem_req_o   = 1'b1;
        mem_nc_o    = mshr_q.nc;
        mem_id_o    = RdTxId;
        mem_paddr_o = mshr_q.nc ? mshr_q.paddr : cl_align(mshr_q.paddr);
        mem_size_o  = mshr_q.nc ? mshr_q.size : 3'b111;
        if (mem_ack_i) begin
          state_d = MSHR_WAIT;
        end
      end

      MSHR_WAIT: begin
        if (mem_rtrn_vld_i) begin
          for (int unsigned i = 0; i < NumPorts; i++) begin
            miss_rtrn_vld_o[i] = (mshr_q.port == MSHR_PORT_WIDTH'(i));
          end
          rtrn_data_o = mem_rtrn_data_i;
          cl_write    = !mshr_q.nc;
          state_d     = MSHR_IDLE;
        end
      end

      default: state_d = MSHR_IDLE;
    endcase

    if (cl_write) begin
      wr_cl_vld_o  = 1'b1;
      wr_cl_we_o   = victim_way;
      wr_cl_idx_o  = cl_idx(mshr_q.paddr);
      wr_cl_tag_o  = cl_tag(mshr_q.paddr);
      wr_cl_data_o = mem_rtrn_data_i;
    end

    // Cacheable requests hitting the in-flight cacheable line must replay.
    if (state_q != MSHR_IDLE && !mshr_q.nc) begin
      for (int unsigned i = 0; i < NumPorts; i++) begin
        miss_replay_o[i] = miss_req_i[i] && !miss_nc_i[i] &&
                           same_line(miss_paddr_i[i*PLEN +: PLEN], mshr_q.paddr);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MSHR_IDLE;
      mshr_q  <= '0;
    end else begin
      state_q <= state_d;
      mshr_q  <= mshr_d;
    end
  end

  wt_dcache_victim_sel i_victim_sel (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .vld_bits_i (mshr_q.vld_bits),
    .upd_i      (cl_write),
    .way_oh_o   (victim_way)
  );

`ifdef WT_DCACHE_MISS_PERF_EN
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [31:0] replay_cnt_q, replay_cnt_d;

  // Saturating event counters.
  always_comb begin
    miss_cnt_d   = miss_cnt_q;
    replay_cnt_d = replay_cnt_q;
    if (|miss_ack_o && miss_cnt_q != 32'hFFFF_FFFF) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
    if (|miss_replay_o && replay_cnt_q != 32'hFFFF_FFFF) begin
      replay_cnt_d = replay_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      miss_cnt_q   <= '0;
      replay_cnt_q <= '0;
    end else begin
      miss_cnt_q   <= miss_cnt_d;
      replay_cnt_q <= replay_cnt_d;
    end
  end

  assign miss_cnt_o   = miss_cnt_q;
  assign replay_cnt_o = replay_cnt_q;
`else
  assign miss_cnt_o   = '0;
  assign replay_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wt_dcache_miss_rsp.sv
// Randomized bench for wt_dcache_miss_rsp against a transaction-level model.
module tb_wt_dcache_miss_rsp;
  import wt_cache_pkg::*;

  localparam int unsigned NP    = 3;
  localparam int unsigned SA    = DCACHE_SET_ASSOC;
  localparam longint unsigned LB    = DCACHE_LINE_WIDTH / 8;
  localparam longint unsigned NSETS = longint'(1) << DCACHE_CL_IDX_WIDTH;

  logic                          clk_i = 1'b0;
  logic                          rst_ni = 1'b0;
  logic [NP-1:0]                 miss_req_i = '0;
  logic [NP-1:0]                 miss_ack_o;
  logic [NP-1:0]                 miss_replay_o;
  logic [NP-1:0]                 miss_nc_i = '0;
  logic [NP*PLEN-1:0]            miss_paddr_i;
  logic [NP*3-1:0]               miss_size_i;
  logic [NP*SA-1:0]              miss_vld_bits_i;
  logic [NP-1:0]                 miss_rtrn_vld_o;
  logic [DCACHE_LINE_WIDTH-1:0]  rtrn_data_o;
  logic                          mem_req_o;
  logic                          mem_ack_i = 1'b0;
  logic [PLEN-1:0]               mem_paddr_o;
  logic [2:0]                    mem_size_o;
  logic                          mem_nc_o;
  logic [CACHE_ID_WIDTH-1:0]     mem_id_o;
  logic                          mem_rtrn_vld_i = 1'b0;
  logic [DCACHE_LINE_WIDTH-1:0]  mem_rtrn_data_i = '0;
  logic                          wr_cl_vld_o;
  logic [SA-1:0]                 wr_cl_we_o;
  logic [DCACHE_CL_IDX_WIDTH-1:0] wr_cl_idx_o;
  logic [DCACHE_TAG_WIDTH-1:0]   wr_cl_tag_o;
  logic [DCACHE_LINE_WIDTH-1:0]  wr_cl_data_o;
  logic [31:0]                   miss_cnt_o;
  logic [31:0]                   replay_cnt_o;

  logic [PLEN-1:0] t_paddr [NP];
  logic [2:0]      t_size  [NP];
  logic [SA-1:0]   t_vb    [NP];

  int n_chk  = 0;
  int n_pass = 0;
  int m_rr     = 0;
  int m_miss   = 0;
  int m_replay = 0;

  always #5 clk_i = ~clk_i;

  always_comb begin
    miss_paddr_i    = '0;
    miss_size_i     = '0;
    miss_vld_bits_i = '0;
    for (int i = 0; i < NP; i++) begin
      miss_paddr_i[i*PLEN +: PLEN]  = t_paddr[i];
      miss_size_i[i*3 +: 3]         = t_size[i];
      miss_vld_bits_i[i*SA +: SA]   = t_vb[i];
    end
  end

  wt_dcache_miss_rsp #(.NumPorts(NP), .RdTxId(CACHE_ID_WIDTH'(1))) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .miss_req_i      (miss_req_i),
    .miss_ack_o      (miss_ack_o),
    .miss_replay_o   (miss_replay_o),
    .miss_nc_i       (miss_nc_i),
    .miss_paddr_i    (miss_paddr_i),
    .miss_size_i     (miss_size_i),
    .miss_vld_bits_i (miss_vld_bits_i),
    .miss_rtrn_vld_o (miss_rtrn_vld_o),
    .rtrn_data_o     (rtrn_data_o),
    .mem_req_o       (mem_req_o),
    .mem_ack_i       (mem_ack_i),
    .mem_paddr_o     (mem_paddr_o),
    .mem_size_o      (mem_size_o),
    .mem_nc_o        (mem_nc_o),
    .mem_id_o        (mem_id_o),
    .mem_rtrn_vld_i  (mem_rtrn_vld_i),
    .mem_rtrn_data_i (mem_rtrn_data_i),
    .wr_cl_vld_o     (wr_cl_vld_o),
    .wr_cl_we_o      (wr_cl_we_o),
    .wr_cl_idx_o     (wr_cl_idx_o),
    .wr_cl_tag_o     (wr_cl_tag_o),
    .wr_cl_data_o    (wr_cl_data_o),
    .miss_cnt_o      (miss_cnt_o),
    .replay_cnt_o    (replay_cnt_o)
  );

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int p, input logic [PLEN-1:0] a, input logic nc,
                         input logic [2:0] sz, input logic [SA-1:0] vb);
    miss_req_i[p] = 1'b1;
    miss_nc_i[p]  = nc;
    t_paddr[p]    = a;
    t_size[p]     = sz;
    t_vb[p]       = vb;
  endtask

  // Small address pool so collisions and full sets happen often.
  function automatic logic [PLEN-1:0] gen_addr();
    longint unsigned a;
    a = 64'h8000_0000 + longint'($urandom_range(3, 0)) * 64'h1000
      + longint'($urandom_range(3, 0)) * LB + longint'($urandom_range(3, 0)) * 8;
    return PLEN'(a);
  endfunction

  function automatic logic [NP-1:0] exp_replay(input logic [PLEN-1:0] mp, input logic mn);
    logic [NP-1:0] r;
    r = '0;
    for (int p = 0; p < NP; p++) begin
      if (miss_req_i[p] && !miss_nc_i[p] && !mn &&
          (longint'(t_paddr[p]) / LB) == (longint'(mp) / LB))
        r[p] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [SA-1:0] exp_way(input logic [SA-1:0] vb);
    for (int i = 0; i < SA; i++) if (!vb[i]) return SA'(1) << i;
    return SA'(1) << m_rr;
  endfunction

  task automatic chk_perf();
`ifdef WT_DCACHE_MISS_PERF_EN
    check("miss_cnt", miss_cnt_o, 256'(m_miss));
    check("replay_cnt", replay_cnt_o, 256'(m_replay));
`else
    check("miss_cnt", miss_cnt_o, 256'(0));
    check("replay_cnt", replay_cnt_o, 256'(0));
`endif
  endtask

  task automatic chk_replay(input logic [PLEN-1:0] mp, input logic mn);
    logic [NP-1:0] r;
    r = exp_replay(mp, mn);
    check("replay", miss_replay_o, 256'(r));
    if (r != '0) m_replay++;
  endtask

  task automatic add_random(input logic [PLEN-1:0] mp);
    for (int p = 0; p < NP; p++) begin
      if (!miss_req_i[p] && $urandom_range(1, 0) == 1) begin
        logic [PLEN-1:0] a;
        case ($urandom_range(2, 0))
          0:       a = PLEN'((longint'(mp) / LB) * LB + longint'($urandom_range(3, 0)) * 8);
          1:       a = mp ^ PLEN'(32'h0000_1000);
          default: a = gen_addr();
        endcase
        set_req(p, a, $urandom_range(3, 0) == 0, 3'($urandom_range(7, 0)), SA'($urandom()));
      end
    end
  endtask

  task automatic maybe_kill();
    if ($urandom_range(7, 0) == 0) miss_req_i[$urandom_range(NP - 1, 0)] = 1'b0;
  endtask

  // One full transaction, starting with the DUT idle and requests already driven.
  task automatic do_txn(input int ack_dly, input int rtn_dly, input bit rnd,
                        input int inj_p, input logic [PLEN-1:0] inj_a);
    int w;
    logic [PLEN-1:0] mp;
    logic mn;
    logic [2:0] msz;
    logic [SA-1:0] mvb;
    logic [DCACHE_LINE_WIDTH-1:0] d;
    bit ret;
    longint unsigned la;

    w = -1;
    for (int i = NP - 1; i >= 0; i--) if (miss_req_i[i]) w = i;
    @(negedge clk_i);
    chk_perf();
    check("ack", miss_ack_o, 256'(NP'(1) << w));
    check("idle_replay", miss_replay_o, 256'(0));
    check("idle_mem_req", mem_req_o, 256'(0));
    check("idle_rtrn", miss_rtrn_vld_o, 256'(0));
    mp = t_paddr[w]; mn = miss_nc_i[w]; msz = t_size[w]; mvb = t_vb[w];
    la = longint'(mp);
    m_miss++;
    cyc();
    miss_req_i[w] = 1'b0;
    if (inj_p >= 0) set_req(inj_p, inj_a, 1'b0, 3'b011, '0);
    if (rnd) add_random(mp);

    for (int c = 0; c <= ack_dly; c++) begin
      mem_ack_i = (c == ack_dly);
      @(negedge clk_i);
      check("mem_req", mem_req_o, 256'(1));
      check("mem_paddr", mem_paddr_o, mn ? 256'(mp) : 256'((la / LB) * LB));
      check("mem_size", mem_size_o, mn ? 256'(msz) : 256'(3'b111));
      check("mem_nc", mem_nc_o, 256'(mn));
      check("mem_id", mem_id_o, 256'(1));
      check("issue_ack", miss_ack_o, 256'(0));
      chk_replay(mp, mn);
      cyc();
      if (rnd) maybe_kill();
    end
    mem_ack_i = 1'b0;

    for (int c = 0; c <= rtn_dly; c++) begin
      ret = (c == rtn_dly);
      mem_rtrn_vld_i = ret;
      for (int k = 0; k < DCACHE_LINE_WIDTH / 32; k++) d[k*32 +: 32] = $urandom();
      mem_rtrn_data_i = d;
      @(negedge clk_i);
      check("wait_mem_req", mem_req_o, 256'(0));
      check("wait_ack", miss_ack_o, 256'(0));
      chk_replay(mp, mn);
      check("rtrn_vld", miss_rtrn_vld_o, ret ? 256'(NP'(1) << w) : 256'(0));
      check("rtrn_data", rtrn_data_o, ret ? 256'(d) : 256'(0));
      check("wr_cl_vld", wr_cl_vld_o, 256'(ret && !mn));
      if (ret && !mn) begin
        check("wr_cl_we", wr_cl_we_o, 256'(exp_way(mvb)));
        check("wr_cl_idx", wr_cl_idx_o, 256'((la / LB) % NSETS));
        check("wr_cl_tag", wr_cl_tag_o, 256'(la / (LB * NSETS)));
        check("wr_cl_data", wr_cl_data_o, 256'(d));
        if (&mvb) m_rr = (m_rr + 1) % SA;
      end
      cyc();
      if (rnd && !ret) maybe_kill();
    end
    mem_rtrn_vld_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NP; i++) begin
      t_paddr[i] = '0; t_size[i] = '0; t_vb[i] = '0;
    end
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Reset values
    @(negedge clk_i);
    check("rst_ack", miss_ack_o, 256'(0));
    check("rst_replay", miss_replay_o, 256'(0));
    check("rst_rtrn", miss_rtrn_vld_o, 256'(0));
    check("rst_mem_req", mem_req_o, 256'(0));
    check("rst_mem_paddr", mem_paddr_o, 256'(0));
    check("rst_wr_cl_vld", wr_cl_vld_o, 256'(0));
    check("rst_wr_cl_we", wr_cl_we_o, 256'(0));
    check("rst_rtrn_data", rtrn_data_o, 256'(0));
    cyc();

    set_req(1, 32'h8000_0100, 1'b0, 3'b011, 4'b0000);
    do_txn(0, 0, 1'b0, -1, '0);

    // Single cacheable miss, way 2 is the first invalid one
    set_req(0, 32'h8000_1048, 1'b0, 3'b011, 4'b0011);
    do_txn(1, 2, 1'b0, -1, '0);

    // Arbitration: port 0 before port 2
    set_req(0, 32'h8000_3000, 1'b0, 3'b011, 4'b0001);
    set_req(2, 32'h8000_4000, 1'b0, 3'b011, 4'b0111);
    do_txn(0, 1, 1'b0, -1, '0);
    do_txn(2, 0, 1'b0, -1, '0);

    // Replay: port 2 hits port 1's in-flight line, port 0 elsewhere stalls
    set_req(1, 32'h8000_1040, 1'b0, 3'b011, 4'b0000);
    set_req(2, 32'h8000_1058, 1'b0, 3'b011, 4'b0000);
    do_txn(1, 2, 1'b0, 0, 32'h8000_2000);
    while (miss_req_i != '0) do_txn(0, 0, 1'b0, -1, '0);

    // Non-cacheable
    set_req(0, 32'h1000_0004, 1'b1, 3'b010, 4'b1111);
    do_txn(1, 1, 1'b0, -1, '0);

    // Full set: round-robin victims
    for (int k = 0; k < 5; k++) begin
      set_req(1, PLEN'(32'h8000_5000 + k * 32'h1000), 1'b0, 3'b111, 4'b1111);
      do_txn(0, 0, 1'b0, -1, '0);
    end

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      if (miss_req_i == '0)
        set_req($urandom_range(NP - 1, 0), gen_addr(), $urandom_range(3, 0) == 0,
                3'($urandom_range(7, 0)), SA'($urandom()));
      do_txn($urandom_range(3, 0), $urandom_range(3, 0), 1'b1, -1, '0);
    end

    // Reset in the middle of a transaction
    miss_req_i = '0;
    set_req(0, 32'h8000_6000, 1'b0, 3'b011, 4'b0000);
    @(negedge clk_i);
    check("pre_rst_ack", miss_ack_o, 256'(1));
    cyc();
    miss_req_i = '0;
    @(negedge clk_i);
    check("pre_rst_mem_req", mem_req_o, 256'(1));
    #1 rst_ni = 1'b0;
    #1;
    check("mid_rst_mem_req", mem_req_o, 256'(0));
    check("mid_rst_ack", miss_ack_o, 256'(0));
    m_rr = 0; m_miss = 0; m_replay = 0;
    cyc();
    rst_ni = 1'b1;
    set_req(2, 32'h8000_7020, 1'b0, 3'b011, 4'b1111);
    do_txn(0, 1, 1'b0, -1, '0);
    @(negedge clk_i);
    chk_perf();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
